// File: rtl/cdc_2phase_dst_buffered_pkg.sv
// Shared limits and pointer helper for the buffered two-phase CDC receive endpoint.
package cdc_2phase_dst_buffered_pkg;

    localparam int unsigned MIN_SYNC_STAGES = 2;
    localparam int unsigned MIN_DEPTH       = 1;

    // Circular increment that also wraps correctly for non-power-of-two depths.
    function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/cdc_2phase_dst_buffered_sync.sv
// Multi-flop synchronizer for a single asynchronous level (the two-phase request).
module cdc_2phase_dst_buffered_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through STAGES flops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain[STAGES-1];

endmodule

// File: rtl/cdc_2phase_dst_buffered.sv
// Destination half of the two-phase req/ack/data link. Each request is captured
// into a local FIFO and acknowledged at once, so consumer backpressure only
// stalls the link when the FIFO is full.
module cdc_2phase_dst_buffered
    import cdc_2phase_dst_buffered_pkg::*;
#(
    parameter type         T           = logic,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clear_i,
    input  logic                       isolate_i,
    input  logic                       async_req_i,
    input  T                           async_data_i,
    output logic                       async_ack_o,
    output T                           data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH+1)-1:0] fill_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
        $error("cdc_2phase_dst_buffered: SYNC_STAGES must be at least 2");
    end
    if (DEPTH < MIN_DEPTH) begin : g_bad_depth
        $error("cdc_2phase_dst_buffered: DEPTH must be at least 1");
    end

    (* dont_touch = "true" *) logic ack_q;
    (* dont_touch = "true" *) T     mem [DEPTH];

    logic             req_synced;
    logic             pending;
    logic             push;
    logic             pop;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    cdc_2phase_dst_buffered_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (async_req_i),
        .q_o    (req_synced)
    );

    // Link/FIFO handshake: a slot freed by a pop is reusable in the same cycle.
    always_comb begin
        pending = 1'b0;
        pop     = 1'b0;
        push    = 1'b0;
        pending = (req_synced != ack_q);
        pop     = valid_o && ready_i;
        push    = pending && !isolate_i && !clear_i && ((count < CNT_W'(DEPTH)) || pop);
    end

    // Ack toggle, pointers and occupancy; clear wins over push and pop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear_i) begin
            ack_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                ack_q  <= ~ack_q;
                wr_ptr <= PTR_W'(wrap_inc(32'(wr_ptr), DEPTH));
            end
            if (pop) begin
                rd_ptr <= PTR_W'(wrap_inc(32'(rd_ptr), DEPTH));
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= async_data_i;
        end
    end

    assign async_ack_o = ack_q;
    assign data_o      = mem[rd_ptr];
    assign valid_o     = (count != '0) && !isolate_i;
    assign fill_o      = count;

endmodule

// File: tb/tb_cdc_2phase_dst_buffered.sv
// Self-checking bench for cdc_2phase_dst_buffered (8-bit payload, DEPTH=4, 2 sync stages).
module tb_cdc_2phase_dst_buffered;

    typedef logic [7:0] byte_t;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned SYNC   = 2;
    localparam int unsigned NITEMS = 1000;

    typedef struct {
        byte_t data;
        logic  pop_after;
        byte_t exp_head;
        int    exp_fill3;
        int    exp_fill_after;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic       isolate;
    logic       req;
    byte_t      din;
    logic       ack;
    byte_t      dout;
    logic       valid;
    logic       ready;
    logic [2:0] fill;

    int total = 0;
    int bad   = 0;

    vec_t  vecs [6];
    byte_t iso_exp [3];
    byte_t sb [$];
    bit    ok;
    int    idx;

    always #5 clk = ~clk;

    cdc_2phase_dst_buffered #(
        .T           (byte_t),
        .SYNC_STAGES (SYNC),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .clear_i      (clear),
        .isolate_i    (isolate),
        .async_req_i  (req),
        .async_data_i (din),
        .async_ack_o  (ack),
        .data_o       (dout),
        .valid_o      (valid),
        .ready_i      (ready),
        .fill_o       (fill)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Source model: toggle req with new data, wait (bounded) for the matching ack.
    task automatic send(input byte_t d, output bit done);
        din  = d;
        req  = ~req;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack == req) begin
                done = 1'b1;
                break;
            end
        end
        chk("ack_timeout", int'(done), 1);
    endtask

    task automatic pop_check(input string name, input byte_t exp);
        chk({name, "_valid"}, int'(valid), 1);
        chk({name, "_data"}, int'(dout), int'(exp));
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{data: 8'hA5, pop_after: 1'b1, exp_head: 8'hA5, exp_fill3: 1, exp_fill_after: 0};
        vecs[1] = '{data: 8'h3C, pop_after: 1'b0, exp_head: 8'h3C, exp_fill3: 1, exp_fill_after: 1};
        vecs[2] = '{data: 8'hC3, pop_after: 1'b1, exp_head: 8'h3C, exp_fill3: 2, exp_fill_after: 1};
        vecs[3] = '{data: 8'hFF, pop_after: 1'b1, exp_head: 8'hC3, exp_fill3: 2, exp_fill_after: 1};
        vecs[4] = '{data: 8'h00, pop_after: 1'b1, exp_head: 8'hFF, exp_fill3: 2, exp_fill_after: 1};
        vecs[5] = '{data: 8'h5A, pop_after: 1'b1, exp_head: 8'h00, exp_fill3: 2, exp_fill_after: 1};
        iso_exp[0] = 8'h11;
        iso_exp[1] = 8'h22;
        iso_exp[2] = 8'h33;

        rst_n   = 1'b0;
        clear   = 1'b0;
        isolate = 1'b0;
        req     = 1'b0;
        ready   = 1'b0;
        din     = '0;
        #1;
        chk("reset_ack", int'(ack), 0);
        chk("reset_valid", int'(valid), 0);
        chk("reset_fill", int'(fill), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Table-driven single transfers: latency, ack timing and head ordering.
        for (int i = 0; i < 6; i++) begin
            din = vecs[i].data;
            req = ~req;
            tick();
            tick();
            chk("vec_ack_e2", int'(ack != req), 1);
            chk("vec_fill_e2", int'(fill), vecs[i].exp_fill3 - 1);
            tick();
            chk("vec_ack_e3", int'(ack == req), 1);
            chk("vec_valid_e3", int'(valid), 1);
            chk("vec_head_e3", int'(dout), int'(vecs[i].exp_head));
            chk("vec_fill_e3", int'(fill), vecs[i].exp_fill3);
            ready = vecs[i].pop_after;
            tick();
            ready = 1'b0;
            chk("vec_fill_after", int'(fill), vecs[i].exp_fill_after);
        end
        pop_check("vec_drain", 8'h5A);
        chk("vec_empty", int'(fill), 0);

        // Fill to full, stall the fifth request, then capture it in the pop cycle.
        for (int i = 0; i < 4; i++) begin
            send(byte_t'(i), ok);
        end
        chk("full_fill", int'(fill), 4);
        din = 8'd4;
        req = ~req;
        repeat (10) tick();
        chk("full_stall_ack", int'(ack != req), 1);
        chk("full_stall_fill", int'(fill), 4);
        chk("full_head", int'(dout), 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("full_pop_ack", int'(ack == req), 1);
        chk("full_pop_fill", int'(fill), 4);
        for (int v = 1; v <= 4; v++) begin
            pop_check("full_drain", byte_t'(v));
        end
        chk("full_empty", int'(fill), 0);

        // Isolate: valid masked immediately, pending request held off, then drained in order.
        send(8'h11, ok);
        send(8'h22, ok);
        isolate = 1'b1;
        #1;
        chk("iso_valid_now", int'(valid), 0);
        din = 8'h33;
        req = ~req;
        repeat (8) tick();
        chk("iso_ack_held", int'(ack != req), 1);
        chk("iso_fill", int'(fill), 2);
        chk("iso_valid", int'(valid), 0);
        isolate = 1'b0;
        #1;
        chk("iso_valid_back", int'(valid), 1);
        ready = 1'b1;
        idx   = 0;
        for (int c = 0; c < 20 && idx < 3; c++) begin
            if (valid) begin
                chk("iso_drain_data", int'(dout), int'(iso_exp[idx]));
                idx++;
            end
            tick();
        end
        ready = 1'b0;
        chk("iso_drain_count", idx, 3);
        chk("iso_ack_done", int'(ack == req), 1);
        chk("iso_empty", int'(fill), 0);

        // Clear with stored items and a pending toggle; source cleared alongside.
        send(8'h41, ok);
        send(8'h42, ok);
        send(8'h43, ok);
        chk("clr_fill_before", int'(fill), 3);
        din = 8'h44;
        req = ~req;
        tick();
        clear = 1'b1;
        req   = 1'b0;
        tick();
        chk("clr_fill", int'(fill), 0);
        chk("clr_valid", int'(valid), 0);
        chk("clr_ack", int'(ack), 0);
        tick();
        tick();
        clear = 1'b0;
        tick();
        tick();
        chk("clr_no_capture_fill", int'(fill), 0);
        chk("clr_no_capture_ack", int'(ack), 0);
        send(8'h5C, ok);
        chk("clr_fresh_fill", int'(fill), 1);
        pop_check("clr_fresh", 8'h5C);
        chk("clr_fresh_empty", int'(fill), 0);

        // Random streaming against an in-order scoreboard.
        fork
            begin : source
                byte_t d;
                bit    sent;
                for (int n = 0; n < int'(NITEMS); n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    d = byte_t'($urandom);
                    sb.push_back(d);
                    send(d, sent);
                    if (!sent) break;
                end
            end
            begin : sink
                int    got;
                int    cyc;
                byte_t e;
                got = 0;
                cyc = 0;
                while (got < int'(NITEMS) && cyc < 30000) begin
                    ready = 1'($urandom_range(0, 1));
                    if (valid && ready) begin
                        if (sb.size() == 0) begin
                            chk("stream_extra_item", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("stream_data", int'(dout), int'(e));
                        end
                        got++;
                    end
                    tick();
                    cyc++;
                end
                ready = 1'b0;
                chk("stream_count", got, int'(NITEMS));
            end
        join
        chk("stream_leftover", sb.size(), 0);
        chk("stream_empty", int'(fill), 0);

        // Asynchronous reset while full: outputs return to reset values without a clock.
        for (int i = 0; i < 4; i++) begin
            send(byte_t'(8'h80 + i), ok);
        end
        chk("rst_full_fill", int'(fill), 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_ack", int'(ack), 0);
        chk("rst_async_valid", int'(valid), 0);
        chk("rst_async_fill", int'(fill), 0);
        req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_after_fill", int'(fill), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
